// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-to-parallel deserializer with a one-entry output holding register.
//   Qualified serial bits shift into a WIDTH-bit register. Every WIDTH bits
//   complete a word, which is offered to the consumer on a valid/ready pair.
//   If the holding register is still occupied when the next word completes,
//   that new word is dropped and the sticky overflow flag is set.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: first received bit ends up in word_data[WIDTH-1]
//              0: first received bit ends up in word_data[0]
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   serial_in     serial data bit, sampled when bit_valid = 1
//   bit_valid     qualifies serial_in
//   frame_start   discards the partial word (realignment)
//   word_ready    consumer accepts word_data while word_valid = 1
//   clear_ovf     clears the sticky overflow flag
//   parallel_out  live shift-register contents
//   bit_count     bits collected in the current partial word
//   word_data     completed word
//   word_valid    word_data holds an unconsumed word
//   overflow      sticky: a completed word was dropped
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    input  logic                     bit_valid,
    input  logic                     frame_start,
    input  logic                     word_ready,
    input  logic                     clear_ovf,
    output logic [WIDTH-1:0]         parallel_out,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic [WIDTH-1:0]         word_data,
    output logic                     word_valid,
    output logic                     overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_base;
    logic             complete;
    logic             slot_free;

    // frame_start clears the register before the shift, so a bit arriving in
    // the same cycle becomes the first bit of the new word.
    assign base     = frame_start ? '0 : sreg;
    assign cnt_base = frame_start ? '0 : bit_count;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {base[WIDTH-2:0], serial_in};
        end else begin : g_lsb
            assign shifted = {serial_in, base[WIDTH-1:1]};
        end
    endgenerate

    // With WIDTH >= 2 a realigned count is 0 and can never equal LAST, so
    // frame_start never completes a word.
    assign complete  = bit_valid && (cnt_base == LAST);
    // The holding register can take a new word if it is empty or being
    // drained on this very edge.
    assign slot_free = !word_valid || word_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (bit_valid) begin
            sreg      <= shifted;
            bit_count <= complete ? '0 : cnt_base + CW'(1);
        end else if (frame_start) begin
            sreg      <= '0;
            bit_count <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_data  <= '0;
            word_valid <= 1'b0;
        end else if (complete && slot_free) begin
            word_data  <= shifted;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (complete && !slot_free) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign parallel_out = sreg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
//   Directed bench for sipo_deserializer (WIDTH = 8). Two instances share the
//   inputs: m_* is MSB-first, l_* is LSB-first. A vector table covers the basic
//   framing in both bit orders; hand-written sequences cover gaps, overflow,
//   frame_start realignment and asynchronous reset.
module tb_sipo_deserializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic serial_in, bit_valid, frame_start, word_ready, clear_ovf;

    logic [W-1:0] m_par, m_data, l_par, l_data;
    logic [2:0]   m_cnt, l_cnt;
    logic         m_vld, m_ovf, l_vld, l_ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] xq[$];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_ready(word_ready), .clear_ovf(clear_ovf),
        .parallel_out(m_par), .bit_count(m_cnt), .word_data(m_data),
        .word_valid(m_vld), .overflow(m_ovf)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_ready(word_ready), .clear_ovf(clear_ovf),
        .parallel_out(l_par), .bit_count(l_cnt), .word_data(l_data),
        .word_valid(l_vld), .overflow(l_ovf)
    );

    // Record every transfer of the MSB-first instance.
    always @(posedge clk) begin
        if (mon_en && m_vld && word_ready) xq.push_back(m_data);
    end

    typedef struct {
        logic       si, bv, fs, rdy, co;
        logic [7:0] par;
        logic [2:0] cnt;
        logic       vld;
        logic [7:0] dat;
        logic [7:0] ldat;
        logic       ovf;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle; return at 1 time unit after the edge.
    task automatic step(input logic si, input logic bv, input logic fs,
                        input logic rdy, input logic co);
        serial_in = si; bit_valid = bv; frame_start = fs;
        word_ready = rdy; clear_ovf = co;
        @(posedge clk); #1;
    endtask

    // Send one word MSB-first-ordered (w[7] first), with optional idle gaps,
    // checking that bit_count advances per bit and holds during gaps.
    task automatic send_word(input logic [7:0] w, input int gapmax, input logic rdy);
        for (int i = 0; i < 8; i++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int k = 0; k < g; k++) begin
                step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
                chk("gap_count_hold", 32'(m_cnt), 32'(i));
            end
            step(w[7-i], 1'b1, 1'b0, rdy, 1'b0);
            chk("bit_count", 32'(m_cnt), 32'((i + 1) % 8));
        end
    endtask

    initial begin
        // si bv fs rdy co | par cnt vld dat ldat ovf
        tbl[0]  = '{1,1,0,1,0, 8'h01, 3'd1, 0, 8'h00, 8'h00, 0};
        tbl[1]  = '{0,1,0,1,0, 8'h02, 3'd2, 0, 8'h00, 8'h00, 0};
        tbl[2]  = '{1,1,0,1,0, 8'h05, 3'd3, 0, 8'h00, 8'h00, 0};
        tbl[3]  = '{0,1,0,1,0, 8'h0A, 3'd4, 0, 8'h00, 8'h00, 0};
        tbl[4]  = '{0,1,0,1,0, 8'h14, 3'd5, 0, 8'h00, 8'h00, 0};
        tbl[5]  = '{1,1,0,1,0, 8'h29, 3'd6, 0, 8'h00, 8'h00, 0};
        tbl[6]  = '{0,1,0,1,0, 8'h52, 3'd7, 0, 8'h00, 8'h00, 0};
        tbl[7]  = '{1,1,0,1,0, 8'hA5, 3'd0, 1, 8'hA5, 8'hA5, 0};
        tbl[8]  = '{0,0,0,1,0, 8'hA5, 3'd0, 0, 8'hA5, 8'hA5, 0};
        tbl[9]  = '{1,1,0,1,0, 8'h4B, 3'd1, 0, 8'hA5, 8'hA5, 0};
        tbl[10] = '{1,1,0,1,0, 8'h97, 3'd2, 0, 8'hA5, 8'hA5, 0};
        tbl[11] = '{0,1,0,1,0, 8'h2E, 3'd3, 0, 8'hA5, 8'hA5, 0};
        tbl[12] = '{0,1,0,1,0, 8'h5C, 3'd4, 0, 8'hA5, 8'hA5, 0};
        tbl[13] = '{0,1,0,1,0, 8'hB8, 3'd5, 0, 8'hA5, 8'hA5, 0};
        tbl[14] = '{0,1,0,1,0, 8'h70, 3'd6, 0, 8'hA5, 8'hA5, 0};
        tbl[15] = '{0,1,0,1,0, 8'hE0, 3'd7, 0, 8'hA5, 8'hA5, 0};
        tbl[16] = '{0,1,0,1,0, 8'hC0, 3'd0, 1, 8'hC0, 8'h03, 0};
        tbl[17] = '{0,0,0,1,0, 8'hC0, 3'd0, 0, 8'hC0, 8'h03, 0};

        rst = 1'b1;
        serial_in = 0; bit_valid = 0; frame_start = 0; word_ready = 0; clear_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_m", {m_par, 5'(m_cnt), m_data, m_vld, m_ovf}, 32'h0);
        chk("reset_l", {l_par, 5'(l_cnt), l_data, l_vld, l_ovf}, 32'h0);
        rst = 1'b0;

        // Table: 0xA5 in both orders, then 1,1,0,0,0,0,0,0 (0xC0 / 0x03)
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].si, tbl[i].bv, tbl[i].fs, tbl[i].rdy, tbl[i].co);
            chk($sformatf("v%0d_par", i),  32'(m_par),  32'(tbl[i].par));
            chk($sformatf("v%0d_cnt", i),  32'(m_cnt),  32'(tbl[i].cnt));
            chk($sformatf("v%0d_vld", i),  32'(m_vld),  32'(tbl[i].vld));
            chk($sformatf("v%0d_dat", i),  32'(m_data), 32'(tbl[i].dat));
            chk($sformatf("v%0d_ldat", i), 32'(l_data), 32'(tbl[i].ldat));
            chk($sformatf("v%0d_ovf", i),  32'(m_ovf),  32'(tbl[i].ovf));
        end

        // Gapped bit stream, ready held high: exactly three ordered transfers
        xq.delete();
        mon_en = 1'b1;
        send_word(8'h3C, 2, 1'b1);
        send_word(8'hFF, 2, 1'b1);
        send_word(8'h00, 2, 1'b1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("gap_xfer_count", 32'(xq.size()), 32'd3);
        if (xq.size() == 3) begin
            chk("gap_xfer0", 32'(xq[0]), 32'h3C);
            chk("gap_xfer1", 32'(xq[1]), 32'hFF);
            chk("gap_xfer2", 32'(xq[2]), 32'h00);
        end
        chk("gap_ovf", 32'(m_ovf), 32'd0);

        // Stalled consumer: second word dropped, overflow set
        xq.delete();
        send_word(8'h11, 0, 1'b0);
        chk("stall_vld1", 32'(m_vld), 32'd1);
        send_word(8'h22, 0, 1'b0);
        chk("stall_dat", 32'(m_data), 32'h11);
        chk("stall_ovf", 32'(m_ovf), 32'd1);
        chk("stall_no_xfer", 32'(xq.size()), 32'd0);
        step(0, 0, 0, 1, 0);
        chk("drain_vld", 32'(m_vld), 32'd0);
        chk("drain_dat_hold", 32'(m_data), 32'h11);
        chk("drain_count", 32'(xq.size()), 32'd1);
        if (xq.size() == 1) chk("drain_val", 32'(xq[0]), 32'h11);
        chk("ovf_sticky", 32'(m_ovf), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("ovf_cleared", 32'(m_ovf), 32'd0);

        // Realignment: 5 bits, frame_start with a 1, then 7 zeros -> 0x80
        xq.delete();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0);
        chk("fs_pre_cnt", 32'(m_cnt), 32'd5);
        step(1, 1, 1, 1, 0);
        chk("fs_cnt", 32'(m_cnt), 32'd1);
        chk("fs_par", 32'(m_par), 32'h01);
        chk("fs_vld", 32'(m_vld), 32'd0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0);
        chk("fs_word_vld", 32'(m_vld), 32'd1);
        chk("fs_word_dat", 32'(m_data), 32'h80);
        step(0, 0, 0, 1, 0);
        chk("fs_one_xfer", 32'(xq.size()), 32'd1);
        chk("fs_ovf", 32'(m_ovf), 32'd0);

        // Async reset with a pending word and a partial word
        send_word(8'h77, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        chk("prerst_vld", 32'(m_vld), 32'd1);
        chk("prerst_cnt", 32'(m_cnt), 32'd4);
        bit_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {m_par, 5'(m_cnt), m_data, m_vld, m_ovf}, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_word(8'h5A, 0, 1'b1);
        chk("postrst_vld", 32'(m_vld), 32'd1);
        chk("postrst_dat", 32'(m_data), 32'h5A);
        chk("postrst_ovf", 32'(m_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-to-parallel deserializer; successor to the fixed 4-bit SIPO shift register. Shifts qualified serial bits into a WIDTH-bit register with selectable bit order, frames every WIDTH bits into a word, and presents the word on a valid/ready output with a one-entry holding register. It sits between a bit-serial front end (line receiver, SPI-like link) and word-oriented logic that can stall.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, 1 = first received bit lands in word_data[WIDTH-1]; 0 = first received bit lands in word_data[0].

- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- serial_in  input  1  serial data bit, sampled only when bit_valid = 1.
- bit_valid  input  1  qualifies serial_in for this cycle.
- frame_start  input  1  synchronous realignment: discards the partial word.
- word_ready  input  1  consumer accepts word_data when word_valid = 1.
- clear_ovf  input  1  synchronous clear of overflow.
- parallel_out  output  WIDTH  live shift-register contents, updated every accepted bit.
- bit_count  output  $clog2(WIDTH)  bits collected in current partial word, 0..WIDTH-1.
- word_data  output  WIDTH  completed word; stable while word_valid = 1 and not accepted.
- word_valid  output  1  word_data holds an unconsumed word.
- overflow  output  1  sticky: a completed word was dropped.

## Operation
- Reset values: parallel_out = 0, bit_count = 0, word_data = 0, word_valid = 0, overflow = 0.
- Shift on bit_valid = 1: MSB_FIRST = 1 → sreg <= {sreg[WIDTH-2:0], serial_in}; MSB_FIRST = 0 → sreg <= {serial_in, sreg[WIDTH-1:1]}. bit_valid = 0 → sreg and bit_count hold.
- bit_count increments per accepted bit. When bit_valid = 1 with bit_count = WIDTH-1, the word completes: the new shifted value is the completed word and bit_count wraps to 0. sreg is not cleared on completion; the next word shifts in over it.
- Word completion, holding register free (word_valid = 0, or word_valid = 1 with word_ready = 1 this cycle): word_data <= completed word, word_valid <= 1.
- Word completion, holding register occupied and word_ready = 0: completed word discarded, word_data/word_valid unchanged, overflow <= 1.
- Output handshake: transfer happens when word_valid = 1 and word_ready = 1. If no new word loads that cycle, word_valid <= 0 and word_data holds its last value.
- frame_start = 1: sreg <= 0 and bit_count <= 0, taking priority over shifting. If bit_valid = 1 in the same cycle, that bit is the first bit of the new word: sreg = serial_in shifted into the cleared register, bit_count = 1. frame_start never completes a word and never touches word_data, word_valid, or overflow.
- overflow: set as above; cleared by clear_ovf = 1. Set takes priority when both occur in the same cycle.
- rst asserted mid-word or with word_valid = 1: partial and pending words are lost, and all outputs return to their reset values asynchronously.

## Timing
- Latency: word_valid rises on the same clock edge that samples the WIDTH-th bit, so it is visible in the following cycle.
- Throughput: one bit per cycle sustained. With word_ready held at 1, no overflow occurs at any bit rate.
- Consumer slack: WIDTH cycles at the full bit rate. word_ready must assert no later than the cycle in which the next word completes.
- parallel_out and bit_count update on the edge that samples the bit, with no added pipeline.
- No combinational path from any input to any output. word_ready affects state only.

## Test plan
- Reset, WIDTH = 8, MSB_FIRST = 1, word_ready = 1: serial bits 1,0,1,0,0,1,0,1 on consecutive cycles → word_valid high for one cycle, word_data = 0xA5, bit_count returns to 0, parallel_out = 0xA5.
- MSB_FIRST = 0, same bit sequence → word_data = 0xA5 reversed = 0xA5 for the palindrome. Repeat with bits 1,1,0,0,0,0,0,0 → word_data = 0x03.
- bit_valid toggled randomly with gaps, 3 words of 0x3C, 0xFF, 0x00, word_ready = 1 → exactly 3 transfers in order with correct values, and bit_count holds during gaps.
- word_ready = 0: send 2 full words (0x11, 0x22) → word_data stays 0x11, overflow = 1. Then raise word_ready → one transfer of 0x11. Then pulse clear_ovf → overflow = 0.
- Send 5 bits, pulse frame_start together with bit_valid = 1 and serial_in = 1, then send 7 bits of 0 → word_data = 0x80 (MSB_FIRST = 1), and no word is emitted for the aborted 5 bits.
- Send 4 bits with a word pending, then assert rst between clock edges → all outputs go to 0 immediately, and the next 8 bits form a clean word.
